// File: rtl/band_gain_interp_if.sv
// Stream bundle for band_gain_interp: a frame of band gains in, a stream of bin gains out.
interface band_gain_interp_if #(
    parameter int WIDTH    = 16,
    parameter int NB_BANDS = 22
);
    logic [NB_BANDS*WIDTH-1:0] gains_in;
    logic                      gains_valid;
    logic                      gains_ready;
    logic [WIDTH-1:0]          bin_gain;
    logic [8:0]                bin_idx;
    logic                      bin_valid;
    logic                      bin_last;
    logic                      bin_ready;

    modport master (
        output gains_in, gains_valid, bin_ready,
        input  gains_ready, bin_gain, bin_idx, bin_valid, bin_last
    );

    modport slave (
        input  gains_in, gains_valid, bin_ready,
        output gains_ready, bin_gain, bin_idx, bin_valid, bin_last
    );
endinterface

// File: rtl/band_gain_interp.sv
// Linear interpolation of 22 band gains onto 481 FFT bins (bins 400..480 are zero).
// Define GAIN_CLAMP_EN to clamp negative captured gains to zero before interpolation.
module band_gain_interp #(
    parameter int WIDTH    = 16,
    parameter int NB_BANDS = 22,
    parameter int NB_BINS  = 481
) (
    input  logic              clk,
    input  logic              rst,
    band_gain_interp_if.slave bus
);
    localparam int NB_INTERP = 400;
    localparam int PW        = WIDTH + 25;
    localparam int SW        = WIDTH + 2;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [WIDTH-1:0] r_gains [NB_BANDS];
    logic signed [WIDTH-1:0] w_cap   [NB_BANDS];
    logic [4:0]              r_band;
    logic [6:0]              r_j;
    logic [8:0]              r_idx;

    logic                    w_capture;
    logic                    w_accept;
    logic                    w_last_bin;
    logic                    w_band_end;
    logic                    w_interp_bin;
    logic [4:0]              w_band_lo;
    logic [4:0]              w_band_hi;
    logic [14:0]             w_recip;
    logic signed [WIDTH:0]   w_diff;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_step;
    logic signed [SW-1:0]    w_sum;
    logic                    w_ovf;
    logic [WIDTH-1:0]        w_sat;

    // Last j within a band: band width in bins minus one.
    function automatic logic [6:0] band_last_j(input logic [4:0] b);
        if (b < 5'd8)        return 7'd3;
        else if (b < 5'd12)  return 7'd7;
        else if (b < 5'd15)  return 7'd15;
        else if (b < 5'd17)  return 7'd23;
        else if (b == 5'd17) return 7'd31;
        else if (b == 5'd18) return 7'd47;
        else if (b == 5'd19) return 7'd71;
        else                 return 7'd87;
    endfunction

    function automatic logic [14:0] band_recip(input logic [4:0] b);
        if (b < 5'd8)        return 15'd16384;
        else if (b < 5'd12)  return 15'd8192;
        else if (b < 5'd15)  return 15'd4096;
        else if (b < 5'd17)  return 15'd2731;
        else if (b == 5'd17) return 15'd2048;
        else if (b == 5'd18) return 15'd1365;
        else if (b == 5'd19) return 15'd910;
        else                 return 15'd745;
    endfunction

    generate
        for (genvar gi = 0; gi < NB_BANDS; gi++) begin : g_cap
            logic signed [WIDTH-1:0] w_raw;
            assign w_raw = bus.gains_in[gi*WIDTH +: WIDTH];
`ifdef GAIN_CLAMP_EN
            assign w_cap[gi] = w_raw[WIDTH-1] ? '0 : w_raw;
`else
            assign w_cap[gi] = w_raw;
`endif
        end
    endgenerate

    assign w_capture    = (r_state == S_IDLE) && bus.gains_valid;
    assign w_accept     = (r_state == S_RUN) && bus.bin_ready;
    assign w_last_bin   = (r_idx == 9'(NB_BINS - 1));
    assign w_interp_bin = (r_idx < 9'(NB_INTERP));
    assign w_band_end   = (r_j == band_last_j(r_band));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NB_BANDS; k++) r_gains[k] <= '0;
        end else if (w_capture) begin
            r_gains <= w_cap;
        end
    end

    // Band/j only walk the interpolated region; band parks at 21 for the zero tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_band <= '0;
            r_j    <= '0;
            r_idx  <= '0;
        end else if (w_capture) begin
            r_band <= '0;
            r_j    <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_idx <= w_last_bin ? 9'd0 : r_idx + 9'd1;
            if (w_interp_bin) begin
                if (w_band_end) begin
                    r_j    <= '0;
                    r_band <= r_band + 5'd1;
                end else begin
                    r_j <= r_j + 7'd1;
                end
            end
        end
    end

    assign w_band_lo = (r_band > 5'd20) ? 5'd20 : r_band;
    assign w_band_hi = w_band_lo + 5'd1;
    assign w_recip   = band_recip(w_band_lo);
    assign w_diff    = (WIDTH+1)'(r_gains[w_band_hi]) - (WIDTH+1)'(r_gains[w_band_lo]);
    assign w_prod    = PW'(w_diff) * PW'($signed({1'b0, r_j})) * PW'($signed({1'b0, w_recip}));
    assign w_step    = w_prod >>> 16;
    assign w_sum     = SW'(r_gains[w_band_lo]) + SW'(w_step);
    assign w_ovf     = (w_sum[SW-1:WIDTH-1] != {(SW-WIDTH+1){w_sum[SW-1]}});
    assign w_sat     = !w_ovf ? w_sum[WIDTH-1:0]
                     : (w_sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.gains_valid) w_state_next = S_RUN;
            S_RUN:   if (bus.bin_ready && w_last_bin) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.gains_ready = 1'b0;
        bus.bin_valid   = 1'b0;
        bus.bin_last    = 1'b0;
        bus.bin_gain    = '0;
        bus.bin_idx     = r_idx;
        case (r_state)
            S_IDLE: bus.gains_ready = 1'b1;
            S_RUN: begin
                bus.bin_valid = 1'b1;
                bus.bin_last  = w_last_bin;
                if (w_interp_bin) bus.bin_gain = w_sat;
            end
            default: bus.gains_ready = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_band_gain_interp.sv
// Directed bench for band_gain_interp: a per-bin reference model plus literal spot checks.
module tb_band_gain_interp;
    localparam int W    = 16;
    localparam int NBB  = 22;
    localparam int NBIN = 481;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    band_gain_interp_if #(.WIDTH(W), .NB_BANDS(NBB)) bus ();

    band_gain_interp #(.WIDTH(W), .NB_BANDS(NBB), .NB_BINS(NBIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int edges_tbl [NBB] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 14, 16, 20, 24, 28, 34, 40, 48, 60, 78, 100};
    int stim     [NBB];
    int m_g      [NBB];
    int exp_gain [NBIN];
    int got      [NBIN];
    int exp_idx      = 0;
    int valid_cycles = 0;
    int stall_cycles = 0;
    int ready_mode   = 0;
    int frame_no     = 0;
    bit stalled      = 1'b0;
    int h_gain, h_idx, h_last;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    function automatic int recip_of(input int size);
        case (size)
            4:  return 16384;
            8:  return 8192;
            16: return 4096;
            24: return 2731;
            32: return 2048;
            48: return 1365;
            72: return 910;
            88: return 745;
            default: return 0;
        endcase
    endfunction

    // Expected gain for bin k from the band-edge table and the current model gains.
    function automatic int model_bin(input int k);
        int size, j, lo, hi;
        longint p, s;
        for (int i = 0; i < NBB - 1; i++) begin
            lo = 4 * edges_tbl[i];
            hi = 4 * edges_tbl[i+1];
            if (k >= lo && k < hi) begin
                size = hi - lo;
                j    = k - lo;
                p    = longint'(m_g[i+1] - m_g[i]) * longint'(j) * longint'(recip_of(size));
                s    = longint'(m_g[i]) + (p >>> 16);
                if (s > 32767)  s = 32767;
                if (s < -32768) s = -32768;
                return int'(s);
            end
        end
        return 0;
    endfunction

    initial begin
        bus.bin_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.bin_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Compare process: every accepted bin against the model, every stall for stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("stall_valid", int'(bus.bin_valid), 1);
                chk("stall_gain",  int'($signed(bus.bin_gain)), h_gain);
                chk("stall_idx",   int'(bus.bin_idx), h_idx);
                chk("stall_last",  int'(bus.bin_last), h_last);
            end
            stalled = 1'b0;
            if (bus.bin_valid) begin
                valid_cycles++;
                if (bus.bin_ready) begin
                    if (exp_idx < NBIN) begin
                        chk("bin_idx",  int'(bus.bin_idx), exp_idx);
                        chk("bin_gain", int'($signed(bus.bin_gain)), exp_gain[exp_idx]);
                        chk("bin_last", int'(bus.bin_last), (exp_idx == NBIN - 1) ? 1 : 0);
                        got[exp_idx] = int'($signed(bus.bin_gain));
                    end else begin
                        chk("bin_overrun", exp_idx, NBIN - 1);
                    end
                    exp_idx++;
                end else begin
                    stalled = 1'b1;
                    stall_cycles++;
                    h_gain = int'($signed(bus.bin_gain));
                    h_idx  = int'(bus.bin_idx);
                    h_last = int'(bus.bin_last);
                end
            end
        end
    end

    task automatic set_all(input int v);
        for (int k = 0; k < NBB; k++) stim[k] = v;
    endtask

    task automatic set_varied();
        for (int k = 0; k < NBB; k++) stim[k] = ((k * 7919 + 1234) % 65536) - 32768;
    endtask

    task automatic offer(input bit chk_idle);
        int t;
        for (int k = 0; k < NBB; k++) begin
`ifdef GAIN_CLAMP_EN
            m_g[k] = (stim[k] < 0) ? 0 : stim[k];
`else
            m_g[k] = stim[k];
`endif
            bus.gains_in[k*W +: W] = stim[k][W-1:0];
        end
        for (int k = 0; k < NBIN; k++) exp_gain[k] = model_bin(k);
        @(posedge clk);
        #1;
        exp_idx      = 0;
        valid_cycles = 0;
        stall_cycles = 0;
        bus.gains_valid = 1'b1;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (chk_idle && t == 0) begin
                chk("idle_after_last_valid", int'(bus.bin_valid), 0);
                chk("idle_after_last_ready", int'(bus.gains_ready), 1);
            end
            if (bus.gains_ready) break;
            t++;
            if (t > 2000) begin
                chk("gains_ready_timeout", 0, 1);
                bus.gains_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.gains_valid = 1'b0;
        @(negedge clk);
        chk("first_valid_latency", int'(bus.bin_valid), 1);
        chk("first_idx", int'(bus.bin_idx), 0);
        chk("ready_low_in_run", int'(bus.gains_ready), 0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_idx < NBIN && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (exp_idx < NBIN) chk("frame_timeout", exp_idx, NBIN);
        frame_no++;
        $display("frame %0d: %0d bins accepted, %0d valid cycles, %0d stall cycles",
                 frame_no, exp_idx, valid_cycles, stall_cycles);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.gains_valid = 1'b0;
        bus.gains_in    = '0;

        @(negedge clk);
        chk("reset_gains_ready", int'(bus.gains_ready), 1);
        chk("reset_bin_valid",   int'(bus.bin_valid), 0);
        chk("reset_bin_last",    int'(bus.bin_last), 0);
        chk("reset_bin_gain",    int'(bus.bin_gain), 0);
        chk("reset_bin_idx",     int'(bus.bin_idx), 0);
        #1 rst = 1'b1;

        // Flat 0x4000 frame, no backpressure.
        ready_mode = 0;
        set_all(16384);
        offer(1'b0);
        wait_done();
        chk("flat_valid_cycles", valid_cycles, 481);
        chk("flat_bin0",   got[0],   16384);
        chk("flat_bin399", got[399], 16384);
        chk("flat_bin400", got[400], 0);
        chk("flat_bin480", got[480], 0);
        @(negedge clk);
        chk("post_frame_valid", int'(bus.bin_valid), 0);
        chk("post_frame_ready", int'(bus.gains_ready), 1);

        // Single peak at band 1.
        set_all(0);
        stim[1] = 32767;
        offer(1'b0);
        wait_done();
        chk("peak_bin0", got[0], 0);
        chk("peak_bin1", got[1], 8191);
        chk("peak_bin2", got[2], 16383);
        chk("peak_bin3", got[3], 24575);
        chk("peak_bin4", got[4], 32767);
        chk("peak_bin5", got[5], 24575);
        chk("peak_bin6", got[6], 16383);
        chk("peak_bin7", got[7], 8191);
        chk("peak_bin8", got[8], 0);

        // Same frame under random backpressure.
        ready_mode = 1;
        offer(1'b0);
        wait_done();
        chk("bp_saw_stalls", (stall_cycles > 0) ? 1 : 0, 1);
        chk("bp_bin5", got[5], 24575);

        // Reset in the middle of a frame, then a fresh frame.
        ready_mode = 0;
        set_varied();
        offer(1'b0);
        t = 0;
        while (exp_idx < 200 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #2;
        chk("pre_reset_idx", int'(bus.bin_idx), 200);
        rst = 1'b0;
        #1;
        chk("midreset_valid", int'(bus.bin_valid), 0);
        chk("midreset_ready", int'(bus.gains_ready), 1);
        chk("midreset_idx",   int'(bus.bin_idx), 0);
        chk("midreset_last",  int'(bus.bin_last), 0);
        $display("frame aborted by reset at bin %0d", exp_idx);
        @(negedge clk);
        #1 rst = 1'b1;
        offer(1'b0);
        wait_done();

        // Frame offered while running is ignored.
        for (int k = 0; k < NBB; k++) stim[k] = 1000 * k - 9000;
        offer(1'b0);
        repeat (50) @(posedge clk);
        #1;
        for (int k = 0; k < NBB; k++) bus.gains_in[k*W +: W] = 16'h7000;
        bus.gains_valid = 1'b1;
        @(negedge clk);
        chk("ignore_ready_low", int'(bus.gains_ready), 0);
        @(posedge clk);
        #1;
        bus.gains_valid = 1'b0;
        wait_done();

        // Back-to-back: next frame offered the cycle after bin 480.
        set_all(0);
        stim[0] = -16384;
        offer(1'b1);
        wait_done();
`ifdef GAIN_CLAMP_EN
        chk("neg_bin0", got[0], 0);
        chk("neg_bin1", got[1], 0);
        chk("neg_bin2", got[2], 0);
        chk("neg_bin3", got[3], 0);
`else
        chk("neg_bin0", got[0], -16384);
        chk("neg_bin1", got[1], -12288);
        chk("neg_bin2", got[2], -8192);
        chk("neg_bin3", got[3], -4096);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
